// File: rtl/fft_reorder_buf.sv
// Ping-pong output reorder buffer for the SDF FFT.
// Restores natural bin order, or passes a frame through unchanged in bypass mode.
module fft_reorder_buf #(
  parameter int LOG2N = 5,
  parameter int IN_W  = 24,
  parameter int OUT_W = 16,
  parameter int ROUND = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             bypass,
  input  logic [IN_W-1:0]  din_r,
  input  logic [IN_W-1:0]  din_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic [OUT_W-1:0] dout_r,
  output logic [OUT_W-1:0] dout_i
);

  localparam int N  = 1 << LOG2N;
  localparam int S  = IN_W - OUT_W;
  localparam int RB = (S > 0) ? S - 1 : 0;
  localparam int W2 = 2 * IN_W;
  localparam logic signed [IN_W:0] MAXV =
    (IN_W+1)'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);

  logic [W2-1:0]    mem_q [2*N];
  logic [LOG2N-1:0] wk_q, wk_d;
  logic [LOG2N-1:0] rd_addr_q, rd_addr_d;
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [1:0]       full_q, full_d;
  logic [1:0]       byp_q, byp_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic [OUT_W-1:0] dout_r_q, dout_r_d;
  logic [OUT_W-1:0] dout_i_q, dout_i_d;

  logic             wr_fire, rd_fire, cur_byp;
  logic [LOG2N-1:0] waddr;
  logic [W2-1:0]    rword;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    for (int b = 0; b < LOG2N; b++) bitrev[b] = a[LOG2N-1-b];
  endfunction

  // Rounding can only overflow upward, so only the positive clamp is needed.
  function automatic logic [OUT_W-1:0] reduce(input logic [IN_W-1:0] x);
    logic signed [IN_W:0] t;
    logic signed [IN_W:0] sum;
    t   = $signed({x[IN_W-1], x}) >>> S;
    sum = t + $signed({{IN_W{1'b0}}, x[RB]});
    if (ROUND == 0 || S == 0) return t[OUT_W-1:0];
    if (sum > MAXV) return MAXV[OUT_W-1:0];
    return sum[OUT_W-1:0];
  endfunction

  assign in_ready = !full_q[wr_bank_q];
  assign wr_fire  = in_valid && in_ready;
  assign rd_fire  = full_q[rd_bank_q] && (!out_valid_q || out_ready);
  assign cur_byp  = (wk_q == '0) ? bypass : byp_q[wr_bank_q];
  assign waddr    = cur_byp ? wk_q : bitrev(wk_q);
  assign rword    = mem_q[{rd_bank_q, rd_addr_q}];

  always_comb begin
    wk_d        = wk_q;
    rd_addr_d   = rd_addr_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    full_d      = full_q;
    byp_d       = byp_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    dout_r_d    = dout_r_q;
    dout_i_d    = dout_i_q;
    if (wr_fire) begin
      if (wk_q == '0) byp_d[wr_bank_q] = bypass;
      if (&wk_q) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = !wr_bank_q;
        wk_d              = '0;
      end else begin
        wk_d = wk_q + 1'b1;
      end
    end
    if (rd_fire) begin
      out_valid_d = 1'b1;
      out_last_d  = &rd_addr_q;
      dout_r_d    = reduce(rword[W2-1:IN_W]);
      dout_i_d    = reduce(rword[IN_W-1:0]);
      if (&rd_addr_q) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = !rd_bank_q;
        rd_addr_d         = '0;
      end else begin
        rd_addr_d = rd_addr_q + 1'b1;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[{wr_bank_q, waddr}] <= {din_r, din_i};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wk_q        <= '0;
      rd_addr_q   <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      full_q      <= '0;
      byp_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      dout_r_q    <= '0;
      dout_i_q    <= '0;
    end else begin
      wk_q        <= wk_d;
      rd_addr_q   <= rd_addr_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      full_q      <= full_d;
      byp_q       <= byp_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      dout_r_q    <= dout_r_d;
      dout_i_q    <= dout_i_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign dout_r    = dout_r_q;
  assign dout_i    = dout_i_q;

endmodule

// File: tb/tb_fft_reorder_buf.sv
// Scoreboard bench for fft_reorder_buf: truncating and rounding
// instances share one stimulus stream and one expected queue.
module tb_fft_reorder_buf;

  localparam int N = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        bypass = 1'b0;
  logic        out_ready = 1'b1;
  logic [23:0] din_r = '0;
  logic [23:0] din_i = '0;

  logic        ir0, ov0, ol0, ir1, ov1, ol1;
  logic [15:0] dr0, di0, dr1, di1;

  always #5 clk = ~clk;

  fft_reorder_buf #(.LOG2N(5), .IN_W(24), .OUT_W(16), .ROUND(0)) u_t (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir0),
    .bypass(bypass), .din_r(din_r), .din_i(din_i),
    .out_valid(ov0), .out_ready(out_ready), .out_last(ol0),
    .dout_r(dr0), .dout_i(di0)
  );

  fft_reorder_buf #(.LOG2N(5), .IN_W(24), .OUT_W(16), .ROUND(1)) u_r (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir1),
    .bypass(bypass), .din_r(din_r), .din_i(din_i),
    .out_valid(ov1), .out_ready(out_ready), .out_last(ol1),
    .dout_r(dr1), .dout_i(di1)
  );

  typedef struct {
    logic [15:0] r0, i0, r1, i1;
    logic        last;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int nvec = 0;
  int nfail = 0;
  int cyc = 0;
  int pop_cnt = 0, last_cnt = 0, first_cyc = 0, last_cyc = 0;
  int drops = 0;
  bit watch = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    nvec++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [4:0] bitrev5(input logic [4:0] a);
    for (int b = 0; b < 5; b++) bitrev5[b] = a[4-b];
  endfunction

  // Monitor: a transfer happens at the next edge when valid and ready.
  always @(negedge clk) begin
    if (!reset && ov0 && out_ready) begin
      if (sbq.size() == 0) begin
        chk("unexpected_output", 32'(dr0), 32'hDEAD);
      end else begin
        e = sbq.pop_front();
        chk("dout_r", 32'(dr0), 32'(e.r0));
        chk("dout_i", 32'(di0), 32'(e.i0));
        chk("out_last", 32'(ol0), 32'(e.last));
        chk("rnd_valid", 32'(ov1), 32'd1);
        chk("rnd_dout_r", 32'(dr1), 32'(e.r1));
        chk("rnd_dout_i", 32'(di1), 32'(e.i1));
        chk("rnd_last", 32'(ol1), 32'(e.last));
      end
      if (pop_cnt == 0) first_cyc = cyc;
      last_cyc = cyc;
      pop_cnt++;
      if (ol0) last_cnt++;
    end
  end

  // Stalled output must hold across the following edge.
  logic        hold_p = 1'b0;
  logic [15:0] pr, pi;
  logic        pl;
  always @(negedge clk) begin
    if (hold_p) begin
      chk("hold_valid", 32'(ov0), 32'd1);
      chk("hold_dout_r", 32'(dr0), 32'(pr));
      chk("hold_dout_i", 32'(di0), 32'(pi));
      chk("hold_last", 32'(ol0), 32'(pl));
    end
    hold_p = ov0 && !out_ready && !reset;
    pr = dr0;
    pi = di0;
    pl = ol0;
  end

  always @(negedge clk) if (watch && in_valid && !ir0) drops++;

  task automatic drive(input logic [23:0] r, input logic [23:0] i,
                       input logic b);
    int t = 0;
    din_r = r;
    din_i = i;
    bypass = b;
    in_valid = 1'b1;
    @(negedge clk);
    while (!ir0 && t < 1000) begin
      t++;
      @(negedge clk);
    end
    if (t >= 1000) chk("in_ready_timeout", 32'(ir0), 32'd1);
    @(posedge clk);
    #1;
  endtask

  // Data is arranged so bin j of the output always carries base+j.
  task automatic send_frame(input int base, input bit arr,
                            input logic b0, input int tog, input bit push);
    logic [23:0] rv;
    int v;
    if (push) begin
      for (int j = 0; j < N; j++) begin
        exp_t x;
        x.r0 = 16'(base + j);
        x.i0 = 16'(-(base + j));
        x.r1 = x.r0;
        x.i1 = x.i0;
        x.last = (j == N - 1);
        sbq.push_back(x);
      end
    end
    for (int k = 0; k < N; k++) begin
      v  = arr ? base + k : base + int'(bitrev5(5'(k)));
      rv = 24'(v << 8);
      drive(rv, -rv, (k < tog) ? b0 : !b0);
    end
  endtask

  // Width-reduction corner cases placed at bins 0..5; remaining bins zero.
  logic [23:0] rin  [6] = '{24'h7FFFFF, 24'h000180, 24'hFFFF7F,
                            24'h800000, 24'h0000FF, 24'h7FFF80};
  logic [15:0] rexp_t [6] = '{16'h7FFF, 16'h0001, 16'hFFFF,
                              16'h8000, 16'h0000, 16'h7FFF};
  logic [15:0] rexp_r [6] = '{16'h7FFF, 16'h0002, 16'hFFFF,
                              16'h8000, 16'h0001, 16'h7FFF};

  task automatic send_round();
    int j;
    for (int b = 0; b < N; b++) begin
      exp_t x;
      x.r0 = (b < 6) ? rexp_t[b] : 16'h0;
      x.r1 = (b < 6) ? rexp_r[b] : 16'h0;
      x.i0 = (b < 6) ? 16'h0000 : 16'h0;
      x.i1 = (b < 6) ? 16'h0001 : 16'h0;
      x.last = (b == N - 1);
      sbq.push_back(x);
    end
    for (int k = 0; k < N; k++) begin
      j = int'(bitrev5(5'(k)));
      if (j < 6) drive(rin[j], 24'h000080, 1'b0);
      else       drive(24'h0, 24'h0, 1'b0);
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    while (sbq.size() != 0 && t < 2000) begin
      t++;
      @(posedge clk);
    end
    if (t >= 2000) chk("drain_timeout", 32'(sbq.size()), 32'd0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(ov0), 32'd0);
    chk("rst_last", 32'(ol0), 32'd0);
    chk("rst_dout_r", 32'(dr0), 32'd0);
    chk("rst_dout_i", 32'(di0), 32'd0);
    reset = 1'b0;
    chk("rst_in_ready", 32'(ir0), 32'd1);

    send_frame(0, 1'b0, 1'b0, N, 1'b1);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("latency_valid", 32'(ov0), 32'd1);
    chk("latency_bin0", 32'(dr0), 32'd0);
    wait_drain();

    pop_cnt = 0;
    last_cnt = 0;
    drops = 0;
    watch = 1;
    for (int f = 0; f < 4; f++) send_frame(40 + 32 * f, 1'b0, 1'b0, N, 1'b1);
    in_valid = 1'b0;
    watch = 0;
    wait_drain();
    chk("cont_in_ready_drops", 32'(drops), 32'd0);
    chk("cont_outputs", 32'(pop_cnt), 32'd128);
    chk("cont_span", 32'(last_cyc - first_cyc), 32'd127);
    chk("cont_last_pulses", 32'(last_cnt), 32'd4);

    out_ready = 1'b0;
    fork
      begin
        repeat (80) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
      begin
        send_frame(1000, 1'b0, 1'b0, N, 1'b1);
        send_frame(1032, 1'b0, 1'b0, N, 1'b1);
        @(negedge clk);
        chk("stall_in_ready", 32'(ir0), 32'd0);
        chk("stall_out_valid", 32'(ov0), 32'd1);
        chk("stall_bin0", 32'(dr0), 32'd1000);
        send_frame(1064, 1'b0, 1'b0, N, 1'b1);
        in_valid = 1'b0;
      end
    join
    wait_drain();

    send_frame(200, 1'b0, 1'b0, N, 1'b1);
    send_frame(300, 1'b1, 1'b1, 10, 1'b1);
    send_frame(400, 1'b0, 1'b0, 5, 1'b1);
    in_valid = 1'b0;
    wait_drain();

    send_round();
    in_valid = 1'b0;
    wait_drain();

    out_ready = 1'b0;
    send_frame(500, 1'b0, 1'b0, N, 1'b0);
    for (int k = 0; k < 20; k++) drive(24'h012300, 24'h045600, 1'b0);
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_valid", 32'(ov0), 32'd0);
    chk("mid_rst_dout_r", 32'(dr0), 32'd0);
    chk("mid_rst_dout_i", 32'(di0), 32'd0);
    chk("mid_rst_last", 32'(ol0), 32'd0);
    chk("mid_rst_rnd_valid", 32'(ov1), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    out_ready = 1'b1;
    chk("post_rst_in_ready", 32'(ir0), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    chk("post_rst_idle", 32'(ov0), 32'd0);
    send_frame(600, 1'b0, 1'b0, N, 1'b1);
    in_valid = 1'b0;
    wait_drain();
    chk("final_queue_empty", 32'(sbq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
